// File: rtl/life_step_scheduler.sv
// Generation/edit sequencer for the Life grid engine: one registered pulse per cycle,
// edits win ties, free-running steps paced every 2^speed video frames.
module life_step_scheduler #(
    parameter int GEN_WIDTH   = 16,
    parameter int SPEED_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run_button,
    input  logic                   step_button,
    input  logic                   click,
    input  logic                   frame_start,
    input  logic [SPEED_WIDTH-1:0] speed,
    output logic                   enable,
    output logic                   pointer_select,
    output logic                   running,
    output logic [GEN_WIDTH-1:0]   generation
);

    // Frame counter must reach 2^(2^SPEED_WIDTH - 1) - 1, i.e. 127 for a 3-bit speed.
    localparam int FC_W = (2 ** SPEED_WIDTH) - 1;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t          state;
    logic            run_prev;
    logic            step_prev;
    logic            edit_pending;
    logic            step_pending;
    logic [FC_W-1:0] frame_count;
    logic [FC_W-1:0] frame_limit;

    logic run_rise;
    logic step_rise;
    logic frame_hit;
    logic step_req;
    logic serve_edit;
    logic serve_step;

    always_comb begin
        run_rise    = run_button & ~run_prev;
        step_rise   = step_button & ~step_prev;
        frame_limit = FC_W'(((FC_W + 1)'(1) << speed) - (FC_W + 1)'(1));
        frame_hit   = (state == RUNNING) && frame_start && (frame_count >= frame_limit);
        step_req    = frame_hit || ((state == PAUSED) && step_rise);
        serve_edit  = edit_pending;
        serve_step  = ~edit_pending & step_pending;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= PAUSED;
            running <= 1'b0;
        end else if (run_rise) begin
            case (state)
                PAUSED: begin
                    state   <= RUNNING;
                    running <= 1'b1;
                end
                default: begin
                    state   <= PAUSED;
                    running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_prev  <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            run_prev  <= run_button;
            step_prev <= step_button;
        end
    end

    // Cleared whenever not RUNNING, which also covers the PAUSED->RUNNING restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (state != RUNNING) begin
            frame_count <= '0;
        end else if (frame_start) begin
            if (frame_count >= frame_limit) begin
                frame_count <= '0;
            end else begin
                frame_count <= frame_count + FC_W'(1);
            end
        end
    end

    // A request arriving on the cycle its flag is served re-arms the flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            edit_pending <= 1'b0;
            step_pending <= 1'b0;
        end else begin
            edit_pending <= click | (edit_pending & ~serve_edit);
            step_pending <= step_req | (step_pending & ~serve_step);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable         <= 1'b0;
            pointer_select <= 1'b0;
            generation     <= '0;
        end else begin
            enable         <= serve_step;
            pointer_select <= serve_edit;
            if (serve_step) begin
                generation <= generation + GEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_life_step_scheduler.sv
// Bench for life_step_scheduler: directed scenarios with hand-computed pins plus a
// randomized phase, all checked every cycle against a request-queue model.
module tb_life_step_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run_button = 1'b0;
    logic       step_button = 1'b0;
    logic       click = 1'b0;
    logic       frame_start = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       enable;
    logic       pointer_select;
    logic       running;
    logic [15:0] generation;

    int vectors = 0;
    int miscompares = 0;
    int en_cnt = 0;
    int ps_cnt = 0;

    life_step_scheduler #(.GEN_WIDTH(16), .SPEED_WIDTH(3)) dut (
        .clock(clock),
        .reset(reset),
        .run_button(run_button),
        .step_button(step_button),
        .click(click),
        .frame_start(frame_start),
        .speed(speed),
        .enable(enable),
        .pointer_select(pointer_select),
        .running(running),
        .generation(generation)
    );

    always #5 clock = ~clock;

    // Reference: two single-entry request slots, a run mode and a frame tally.
    bit m_run, m_edit, m_step, m_en, m_ps, prev_run, prev_step;
    bit run_edge, step_edge, was_running;
    int m_frames = 0;
    int m_gen = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_run = 0; m_edit = 0; m_step = 0; m_en = 0; m_ps = 0;
            prev_run = 0; prev_step = 0; m_frames = 0; m_gen = 0;
        end else begin
            run_edge    = run_button && !prev_run;
            step_edge   = step_button && !prev_step;
            was_running = m_run;
            m_en = 0;
            m_ps = 0;
            if (m_edit) begin
                m_ps = 1;
                m_edit = 0;
            end else if (m_step) begin
                m_en = 1;
                m_step = 0;
                m_gen = (m_gen + 1) % 65536;
            end
            if (click) m_edit = 1;
            if (!was_running && step_edge) m_step = 1;
            if (was_running && frame_start) begin
                if (m_frames >= (1 << speed) - 1) begin
                    m_step = 1;
                    m_frames = 0;
                end else begin
                    m_frames = m_frames + 1;
                end
            end
            if (!was_running) m_frames = 0;
            if (run_edge) m_run = !m_run;
            prev_run  = run_button;
            prev_step = step_button;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("enable", int'(enable), int'(m_en));
        check("pointer_select", int'(pointer_select), int'(m_ps));
        check("running", int'(running), int'(m_run));
        check("generation", int'(generation), m_gen);
        check("no_overlap", int'(enable && pointer_select), 0);
        en_cnt += int'(enable);
        ps_cnt += int'(pointer_select);
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic press_run();
        run_button = 1'b1;
        cyc();
        run_button = 1'b0;
        cyc();
    endtask

    task automatic press_step();
        step_button = 1'b1;
        cyc();
        step_button = 1'b0;
        cyc();
    endtask

    int base;
    int guard;

    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        wait_cycles(20);
        check("idle_running", int'(running), 0);
        check("idle_enable", int'(enable), 0);
        check("idle_psel", int'(pointer_select), 0);
        check("idle_gen", int'(generation), 0);

        // Held step button yields exactly one generation.
        base = en_cnt;
        step_button = 1'b1;
        wait_cycles(5);
        step_button = 1'b0;
        wait_cycles(3);
        check("step_one_pulse", en_cnt - base, 1);
        check("step_gen1", int'(generation), 1);
        press_step();
        wait_cycles(3);
        check("step_gen2", int'(generation), 2);

        // speed=2: every 4th frame steps.
        speed = 3'd2;
        press_run();
        base = en_cnt;
        for (int i = 0; i < 12; i++) begin
            frame_start = 1'b1;
            cyc();
            frame_start = 1'b0;
            wait_cycles(2);
        end
        wait_cycles(3);
        check("frames_3_steps", en_cnt - base, 3);
        check("frames_gen5", int'(generation), 5);
        for (int i = 0; i < 2; i++) begin
            frame_start = 1'b1;
            cyc();
            frame_start = 1'b0;
            wait_cycles(2);
        end
        speed = 3'd0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        wait_cycles(3);
        check("speed_drop_gen6", int'(generation), 6);
        press_run();
        wait_cycles(2);

        // Edit and step requested at the same edge.
        click = 1'b1;
        step_button = 1'b1;
        cyc();
        click = 1'b0;
        check("tie_k_en", int'(enable), 0);
        check("tie_k_ps", int'(pointer_select), 0);
        cyc();
        check("tie_k1_ps", int'(pointer_select), 1);
        check("tie_k1_en", int'(enable), 0);
        cyc();
        check("tie_k2_ps", int'(pointer_select), 0);
        check("tie_k2_en", int'(enable), 1);
        step_button = 1'b0;
        wait_cycles(3);
        check("tie_gen7", int'(generation), 7);

        // Step button ignored while running; a pending step survives pausing.
        speed = 3'd7;
        press_run();
        base = en_cnt;
        press_step();
        wait_cycles(10);
        check("run_step_ignored", en_cnt - base, 0);
        speed = 3'd0;
        frame_start = 1'b1;
        run_button = 1'b1;
        cyc();
        frame_start = 1'b0;
        run_button = 1'b0;
        wait_cycles(5);
        check("pause_pending_issued", en_cnt - base, 1);
        check("pause_running", int'(running), 0);
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'b1;
            cyc();
            frame_start = 1'b0;
            cyc();
        end
        wait_cycles(3);
        check("pause_no_more", en_cnt - base, 1);
        check("pause_gen8", int'(generation), 8);

        // Generation wrap: stream steps, then finish by hand while paused.
        press_run();
        frame_start = 1'b1;
        guard = 0;
        while (m_gen != 16'hFFFD && guard < 70000) begin
            cyc();
            guard++;
        end
        frame_start = 1'b0;
        check("wrap_stream_bound", int'(guard < 70000), 1);
        wait_cycles(3);
        press_run();
        wait_cycles(3);
        guard = 0;
        while (m_gen != 16'hFFFF && guard < 10) begin
            press_step();
            wait_cycles(2);
            guard++;
        end
        check("wrap_gen_ffff", int'(generation), 65535);
        press_step();
        wait_cycles(3);
        check("wrap_gen_zero", int'(generation), 0);

        // Reset while an edit is pending drops it.
        base = ps_cnt;
        click = 1'b1;
        cyc();
        click = 1'b0;
        #2;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_cycles(6);
        check("reset_drops_edit", ps_cnt - base, 0);
        check("reset_gen", int'(generation), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            click       = ($urandom_range(0, 7) == 0);
            frame_start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) step_button = ~step_button;
            if ($urandom_range(0, 39) == 0) run_button = ~run_button;
            if ($urandom_range(0, 49) == 0) speed = 3'($urandom_range(0, 3));
            reset = ($urandom_range(0, 499) == 0);
            cyc();
        end
        reset = 1'b0;
        click = 1'b0;
        frame_start = 1'b0;
        wait_cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
